sdram_arbit: RTL and testbench
==============================

SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 Parameter NOP_CMD, default 4'b0111, command {cs_n,ras_n,cas_n,we_n} driven when no requester owns the bus.
REQ-002 Parameter IDLE_ADDR, default 13'd0, sdram_addr value when no requester owns the bus.
REQ-003 Clock and reset SHALL be sclk and s_rst_n; s_rst_n is asynchronous, active-low.
REQ-004 sclk  in  1  system clock, all state on rising edge.
REQ-005 s_rst_n  in  1  asynchronous active-low reset.
REQ-006 init_cmd  in  4 / init_addr  in  13 / init_end  in  1  init sequencer command, address, done level.
REQ-007 ref_req  in  1 / ref_end  in  1 / ref_cmd  in  4 / ref_addr  in  13  auto-refresh requester.
REQ-008 wr_req  in  1 / wr_end  in  1 / wr_cmd  in  4 / wr_addr  in  13 / wr_bank  in  2  write requester.
REQ-009 rd_req  in  1 / rd_end  in  1 / rd_cmd  in  4 / rd_addr  in  13 / rd_bank  in  2  read requester.
REQ-010 ref_en, wr_en, rd_en  out  1 each  grant, high for every cycle the requester owns the bus.
REQ-011 sdram_cmd  out  4 / sdram_addr  out  13 / sdram_bank  out  2  muxed SDRAM command bus.
REQ-012 sdram_cke  out  1  clock enable.
REQ-013 arb_state  out  3  current state encoding, for debug.

Function
REQ-014 States SHALL be INIT=3'd0, ARBIT=3'd1, AREF=3'd2, WRITE=3'd3, READ=3'd4; all others SHALL recover to ARBIT next cycle.
REQ-015 INIT: leave for ARBIT on the first cycle init_end=1; INIT is entered only from reset.
REQ-016 ARBIT priority: ref_req > write/read; ref_req=1 -> AREF next cycle regardless of wr_req/rd_req.
REQ-017 ARBIT, ref_req=0, exactly one of wr_req/rd_req = 1 -> WRITE or READ respectively, next cycle.
REQ-018 ARBIT, ref_req=0, wr_req=rd_req=1 -> grant the one NOT served last (round-robin flag last_rw, updated on entry to WRITE/READ).
REQ-019 ARBIT with no request: remain in ARBIT.
REQ-020 AREF/WRITE/READ: remain until matching *_end=1 sampled, then ARBIT next cycle; non-matching *_end and all *_req ignored.
REQ-021 Grant latency: request sampled in ARBIT at cycle N -> *_en=1 from cycle N+1; *_end at cycle M -> *_en=0 at M+1; every grant is separated by at least one ARBIT cycle.
REQ-022 ref_en/wr_en/rd_en SHALL be registered, exactly equal to (state==AREF/WRITE/READ); at most one high at any time.
REQ-023 sdram_cmd/sdram_addr SHALL be a combinational mux on registered state: INIT -> init_*, AREF -> ref_*, WRITE -> wr_*, READ -> rd_*, ARBIT -> NOP_CMD/IDLE_ADDR; zero added latency.
REQ-024 sdram_bank = wr_bank in WRITE, rd_bank in READ, 2'b00 otherwise.
REQ-025 sdram_cke SHALL be 1 in every state after reset release.
REQ-026 *_end asserted in the same cycle the state is entered is honoured (one-cycle grant legal).
REQ-027 Requesters hold *_req high until granted; the arbiter SHALL NOT latch requests.

Reset
REQ-028 On s_rst_n=0: state=INIT, ref_en=wr_en=rd_en=0, last_rw=READ (write wins first tie), arb_state=3'd0.
REQ-029 During reset sdram_cmd follows init_cmd, sdram_addr follows init_addr, sdram_bank=2'b00, sdram_cke=0.
REQ-030 Reset asserted mid-grant SHALL drop *_en immediately (asynchronous) and restart in INIT.

Verification
REQ-031 init_end=0 for 50 cycles then 1 -> arb_state 0 for 50 cycles, 1 on the next; sdram_cmd tracks init_cmd, then 4'b0111.
REQ-032 ARBIT, ref_req=wr_req=rd_req=1 same cycle -> ref_en=1 next cycle; ref_end after 8 cycles -> one ARBIT cycle, then wr_en=1.
REQ-033 wr_req=rd_req=1 held continuously, ref_req=0 -> grants alternate WRITE, READ, WRITE..., one ARBIT cycle between each.
REQ-034 In WRITE, pulse rd_end and ref_end -> wr_en stays 1; wr_end -> wr_en=0 next cycle; sdram_bank=wr_bank=2'b10 while in WRITE.
REQ-035 Assert s_rst_n=0 during READ -> rd_en=0 immediately, arb_state=0, sdram_cke=0; re-init required before next grant.

Source files
------------

// File: rtl/sdram_arbit.sv
// SDRAM command bus arbiter.
// Owns the bus through initialisation, then shares it between the
// auto-refresh, write and read requesters. Refresh always wins; when write
// and read collide they take turns.
module sdram_arbit #(
  parameter logic [3:0]  NOP_CMD   = 4'b0111,
  parameter logic [12:0] IDLE_ADDR = 13'd0
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic        init_end,
  input  logic        ref_req,
  input  logic        ref_end,
  input  logic [3:0]  ref_cmd,
  input  logic [12:0] ref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [12:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [12:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic        ref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [3:0]  sdram_cmd,
  output logic [12:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic        sdram_cke,
  output logic [2:0]  arb_state
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  // Which of write/read was served most recently; the other wins a tie.
  localparam logic LAST_WR = 1'b0;
  localparam logic LAST_RD = 1'b1;

  state_t state;
  state_t state_nxt;
  logic   last_rw;
  logic   last_rw_nxt;

  // Next-state decision: priority refresh, then write/read round-robin.
  always_comb begin
    state_nxt   = state;
    last_rw_nxt = last_rw;
    case (state)
      INIT: begin
        if (init_end) state_nxt = ARBIT;
      end
      ARBIT: begin
        if (ref_req) begin
          state_nxt = AREF;
        end else if (wr_req && (!rd_req || last_rw == LAST_RD)) begin
          state_nxt   = WRITE;
          last_rw_nxt = LAST_WR;
        end else if (rd_req) begin
          state_nxt   = READ;
          last_rw_nxt = LAST_RD;
        end
      end
      AREF: begin
        if (ref_end) state_nxt = ARBIT;
      end
      WRITE: begin
        if (wr_end) state_nxt = ARBIT;
      end
      READ: begin
        if (rd_end) state_nxt = ARBIT;
      end
      default: state_nxt = ARBIT;
    endcase
  end

  // State register with grants and clock enable registered alongside it.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state     <= INIT;
      last_rw   <= LAST_RD;
      ref_en    <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      sdram_cke <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_rw   <= last_rw_nxt;
      ref_en    <= (state_nxt == AREF);
      wr_en     <= (state_nxt == WRITE);
      rd_en     <= (state_nxt == READ);
      sdram_cke <= 1'b1;
    end
  end

  // Command bus mux driven straight from the registered state.
  always_comb begin
    sdram_cmd  = NOP_CMD;
    sdram_addr = IDLE_ADDR;
    sdram_bank = 2'b00;
    case (state)
      INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      AREF: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
      end
      WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: begin
        sdram_cmd  = NOP_CMD;
        sdram_addr = IDLE_ADDR;
      end
    endcase
  end

  assign arb_state = state;

endmodule

// File: tb/tb_sdram_arbit.sv
// Testbench for sdram_arbit: directed scenarios followed by random traffic,
// every cycle compared against a bus-ownership model.
module tb_sdram_arbit;

  logic        sclk = 1'b0;
  logic        s_rst_n = 1'b1;
  logic [3:0]  init_cmd = 4'h0;
  logic [12:0] init_addr = 13'd0;
  logic        init_end = 1'b0;
  logic        ref_req = 1'b0, ref_end = 1'b0;
  logic [3:0]  ref_cmd = 4'h1;
  logic [12:0] ref_addr = 13'd0;
  logic        wr_req = 1'b0, wr_end = 1'b0;
  logic [3:0]  wr_cmd = 4'h4;
  logic [12:0] wr_addr = 13'd0;
  logic [1:0]  wr_bank = 2'b00;
  logic        rd_req = 1'b0, rd_end = 1'b0;
  logic [3:0]  rd_cmd = 4'h5;
  logic [12:0] rd_addr = 13'd0;
  logic [1:0]  rd_bank = 2'b00;
  logic        ref_en, wr_en, rd_en;
  logic [3:0]  sdram_cmd;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic        sdram_cke;
  logic [2:0]  arb_state;

  int checks = 0;
  int errors = 0;

  // Model: who owns the bus (0 init, 1 idle, 2 refresh, 3 write, 4 read).
  localparam int O_INIT = 0, O_IDLE = 1, O_REF = 2, O_WR = 3, O_RD = 4;
  int owner;
  bit writeOwed;
  bit ckeUp;

  sdram_arbit dut (
    .sclk(sclk), .s_rst_n(s_rst_n),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_end(init_end),
    .ref_req(ref_req), .ref_end(ref_end), .ref_cmd(ref_cmd), .ref_addr(ref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .sdram_cke(sdram_cke), .arb_state(arb_state)
  );

  // 100 MHz system clock.
  always #5 sclk = ~sclk;

  task automatic modelReset();
    owner     = O_INIT;
    writeOwed = 1'b1;
    ckeUp     = 1'b0;
  endtask

  // One clock of bus ownership rules, evaluated on the sampled inputs.
  task automatic modelEdge();
    ckeUp = 1'b1;
    case (owner)
      O_INIT: if (init_end) owner = O_IDLE;
      O_IDLE: begin
        if (ref_req) owner = O_REF;
        else if (wr_req && rd_req) owner = writeOwed ? O_WR : O_RD;
        else if (wr_req) owner = O_WR;
        else if (rd_req) owner = O_RD;
        if (owner == O_WR) writeOwed = 1'b0;
        if (owner == O_RD) writeOwed = 1'b1;
      end
      O_REF: if (ref_end) owner = O_IDLE;
      O_WR:  if (wr_end)  owner = O_IDLE;
      O_RD:  if (rd_end)  owner = O_IDLE;
      default: owner = O_IDLE;
    endcase
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string where);
    logic [3:0]  eCmd;
    logic [12:0] eAddr;
    logic [1:0]  eBank;
    eCmd = 4'b0111; eAddr = 13'd0; eBank = 2'b00;
    case (owner)
      O_INIT: begin eCmd = init_cmd; eAddr = init_addr; end
      O_REF:  begin eCmd = ref_cmd;  eAddr = ref_addr;  end
      O_WR:   begin eCmd = wr_cmd;   eAddr = wr_addr;  eBank = wr_bank; end
      O_RD:   begin eCmd = rd_cmd;   eAddr = rd_addr;  eBank = rd_bank; end
      default: ;
    endcase
    chk({where, ".arb_state"},  16'(arb_state),  16'(owner));
    chk({where, ".ref_en"},     16'(ref_en),     16'(owner == O_REF));
    chk({where, ".wr_en"},      16'(wr_en),      16'(owner == O_WR));
    chk({where, ".rd_en"},      16'(rd_en),      16'(owner == O_RD));
    chk({where, ".sdram_cmd"},  16'(sdram_cmd),  16'(eCmd));
    chk({where, ".sdram_addr"}, 16'(sdram_addr), 16'(eAddr));
    chk({where, ".sdram_bank"}, 16'(sdram_bank), 16'(eBank));
    chk({where, ".sdram_cke"},  16'(sdram_cke),  16'(ckeUp));
  endtask

  // Advance one clock: inputs already set, compare 1 ns after the edge.
  task automatic applyStimulus(input string where);
    @(posedge sclk);
    modelEdge();
    #1;
    checkOutput(where);
  endtask

  task automatic randPayload();
    init_cmd = 4'($urandom);  init_addr = 13'($urandom);
    ref_cmd  = 4'($urandom);  ref_addr  = 13'($urandom);
    wr_cmd   = 4'($urandom);  wr_addr   = 13'($urandom); wr_bank = 2'($urandom);
    rd_cmd   = 4'($urandom);  rd_addr   = 13'($urandom); rd_bank = 2'($urandom);
  endtask

  initial begin
    // Reset entry and hold.
    modelReset();
    #1 s_rst_n = 1'b0;
    init_cmd = 4'hA; init_addr = 13'h155;
    #1 checkOutput("async_reset");
    @(posedge sclk); #1 checkOutput("reset_held");
    s_rst_n = 1'b1;

    // Initialisation: 50 cycles waiting, then done.
    for (int i = 0; i < 50; i++) begin
      randPayload();
      applyStimulus("init_wait");
    end
    init_end = 1'b1;
    applyStimulus("init_done");
    init_end = 1'b0;
    chk("init_exit_cmd", 16'(sdram_cmd), 16'h7);
    applyStimulus("idle");

    // All three requesters at once: refresh first, then write.
    ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    applyStimulus("triple_req");
    ref_req = 1'b0;
    for (int i = 0; i < 7; i++) applyStimulus("ref_hold");
    ref_end = 1'b1;
    applyStimulus("ref_end");
    ref_end = 1'b0;
    wr_bank = 2'b10;
    applyStimulus("after_ref");
    chk("write_after_ref", 16'(wr_en), 16'h1);

    // Foreign end strobes are ignored while writing.
    rd_end = 1'b1; ref_end = 1'b1;
    applyStimulus("foreign_end");
    rd_end = 1'b0; ref_end = 1'b0;
    chk("write_bank", 16'(sdram_bank), 16'h2);
    wr_end = 1'b1;
    applyStimulus("wr_end");
    wr_end = 1'b0;

    // Continuous write+read requests alternate, one-cycle grants.
    for (int i = 0; i < 12; i++) begin
      wr_end = (owner == O_WR);
      rd_end = (owner == O_RD);
      applyStimulus("alternate");
    end
    wr_req = 1'b0; rd_req = 1'b0; wr_end = 1'b0; rd_end = 1'b0;

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      randPayload();
      ref_req  = ($urandom_range(0, 7) == 0);
      wr_req   = ($urandom_range(0, 2) == 0);
      rd_req   = ($urandom_range(0, 2) == 0);
      ref_end  = ($urandom_range(0, 3) == 0);
      wr_end   = ($urandom_range(0, 3) == 0);
      rd_end   = ($urandom_range(0, 3) == 0);
      init_end = 1'($urandom);
      applyStimulus("random");
    end

    // Return to idle, then obtain a read grant.
    ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    ref_end = 1'b1; wr_end = 1'b1; rd_end = 1'b1;
    applyStimulus("drain");
    ref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 20 && owner != O_RD; i++) applyStimulus("seek_read");
    chk("read_reached", 16'(owner == O_RD), 16'h1);
    rd_req = 1'b0;

    // Reset in the middle of a read grant drops it at once.
    s_rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("mid_read_reset");
    @(posedge sclk); #1 s_rst_n = 1'b1;

    // No grant until initialisation completes again.
    wr_req = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus("reinit_wait");
    init_end = 1'b1;
    applyStimulus("reinit_done");
    init_end = 1'b0;
    applyStimulus("grant_after_reinit");
    wr_req = 1'b0; wr_end = 1'b1;
    applyStimulus("final_end");
    wr_end = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
